// File: rtl/test_sequencer.sv
// Deterministic test-point scheduler: DUT-clock-aligned read/write strobes, point and error counting.
// Optional SEQ_STOP_ON_ERROR_EN: the first counted mismatch ends the run early and sets o_aborted.
module test_sequencer #(
  parameter int DUT_CLK_FREQ  = 100_000_000,
  parameter int SAMPLE_FREQ   = 10_000_000,
  parameter int CHECK_LATENCY = 3,
  parameter int PNT_W         = 16,
  parameter int ERR_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [PNT_W-1:0] i_vector_size,
  input  logic             i_mismatch,
  output logic             o_read_strobe,
  output logic             o_write_strobe,
  output logic [PNT_W-1:0] o_point_index,
  output logic [ERR_W-1:0] o_error_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_test_passed
`ifdef SEQ_STOP_ON_ERROR_EN
  ,
  output logic             o_aborted
`endif
);

  localparam int DIV   = DUT_CLK_FREQ / SAMPLE_FREQ;
  localparam int DIV_W = $clog2(DIV);
  localparam int LAT   = CHECK_LATENCY;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [PNT_W-1:0] PNT_ONE  = PNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [DIV_W-1:0] r_div;
  logic [PNT_W-1:0] r_issued;
  logic [PNT_W-1:0] r_size;
  logic [PNT_W-1:0] r_point_index;
  logic [LAT-1:0]   r_pipe;
  logic [ERR_W-1:0] r_err;
  logic             r_done;
  logic             r_test_passed;

  logic             w_start_ok;
  logic             w_read;
  logic             w_last_read;
  logic             w_write;
  logic             w_hit;
  logic             w_abort;
  logic             w_abort_run;
  logic [LAT-1:0]   w_pipe_next;
  logic [ERR_W-1:0] w_err_next;

  always_comb begin
    w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_read      = (r_state == S_RUN) && (r_div == '0);
    w_last_read = w_read && (r_issued == (r_size - PNT_ONE));
    w_write     = r_pipe[LAT-1];
    w_hit       = w_write && i_mismatch;
    w_pipe_next = (r_pipe << 1) | LAT'(w_read);
  end

  // Saturating mismatch counter; only the write_strobe cycle carries a valid compare.
  always_comb begin
    w_err_next = r_err;
    if (w_start_ok) begin
      w_err_next = '0;
    end else if (w_hit && !(&r_err)) begin
      w_err_next = r_err + ERR_ONE;
    end
  end

`ifdef SEQ_STOP_ON_ERROR_EN
  logic r_abort_seen;
  logic r_aborted;

  assign w_abort     = w_hit;
  assign w_abort_run = r_abort_seen || w_hit;
  assign o_aborted   = r_aborted;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_abort_seen <= 1'b0;
      r_aborted    <= 1'b0;
    end else if (w_start_ok) begin
      r_abort_seen <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      if (w_hit) begin
        r_abort_seen <= 1'b1;
      end
      if ((r_state == S_DRAIN) && (w_next_state == S_DONE)) begin
        r_aborted <= w_abort_run;
      end
    end
  end
`else
  assign w_abort     = 1'b0;
  assign w_abort_run = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          w_next_state = (i_vector_size == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_read || w_abort) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave once the strobe now leaving the pipe was the last one in flight.
        if (w_pipe_next == '0) begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div         <= '0;
      r_issued      <= '0;
      r_size        <= '0;
      r_point_index <= '0;
      r_pipe        <= '0;
      r_err         <= '0;
    end else begin
      r_pipe <= w_pipe_next;
      r_err  <= w_err_next;
      if (w_start_ok) begin
        r_div         <= '0;
        r_issued      <= '0;
        r_size        <= i_vector_size;
        r_point_index <= '0;
      end else begin
        if (r_state == S_RUN) begin
          r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
        end else begin
          r_div <= '0;
        end
        if (w_read) begin
          r_issued      <= r_issued + PNT_ONE;
          r_point_index <= r_issued;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done        <= 1'b0;
      r_test_passed <= 1'b0;
    end else begin
      r_done <= (w_next_state == S_DONE);
      if (w_start_ok) begin
        r_test_passed <= (i_vector_size == '0);
      end else if ((r_state == S_DRAIN) && (w_next_state == S_DONE)) begin
        r_test_passed <= (w_err_next == '0) && !w_abort_run;
      end
    end
  end

  assign o_read_strobe  = w_read;
  assign o_write_strobe = w_write;
  assign o_point_index  = r_point_index;
  assign o_error_count  = r_err;
  assign o_busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done         = r_done;
  assign o_test_passed  = r_test_passed;

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: two instances (DIV=10/LAT=3/ERR_W=2 and DIV=2/LAT=4),
// directed and randomized runs checked against a strobe-timing model derived from the schedule rules.
module tb_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [15:0] vs;
  logic        mm;
  int          sel;

  logic        startA, startB, mmA, mmB;
  logic        rdA, wrA, busyA, doneA, passA;
  logic        rdB, wrB, busyB, doneB, passB;
  logic [15:0] idxA, idxB;
  logic [1:0]  errA;
  logic [15:0] errB;
  logic        abA, abB;

  logic        rd, wr, busy, done, passed, ab;
  logic [15:0] idx;
  logic [31:0] err;

  assign startA = start && (sel == 0);
  assign startB = start && (sel == 1);
  assign mmA    = mm && (sel == 0);
  assign mmB    = mm && (sel == 1);

  test_sequencer #(
    .DUT_CLK_FREQ(100_000_000), .SAMPLE_FREQ(10_000_000),
    .CHECK_LATENCY(3), .PNT_W(16), .ERR_W(2)
  ) dutA (
    .i_clk(clk), .i_rst(rst), .i_start(startA), .i_vector_size(vs), .i_mismatch(mmA),
    .o_read_strobe(rdA), .o_write_strobe(wrA), .o_point_index(idxA), .o_error_count(errA),
    .o_busy(busyA), .o_done(doneA), .o_test_passed(passA)
`ifdef SEQ_STOP_ON_ERROR_EN
    , .o_aborted(abA)
`endif
  );

  test_sequencer #(
    .DUT_CLK_FREQ(20_000_000), .SAMPLE_FREQ(10_000_000),
    .CHECK_LATENCY(4), .PNT_W(16), .ERR_W(16)
  ) dutB (
    .i_clk(clk), .i_rst(rst), .i_start(startB), .i_vector_size(vs), .i_mismatch(mmB),
    .o_read_strobe(rdB), .o_write_strobe(wrB), .o_point_index(idxB), .o_error_count(errB),
    .o_busy(busyB), .o_done(doneB), .o_test_passed(passB)
`ifdef SEQ_STOP_ON_ERROR_EN
    , .o_aborted(abB)
`endif
  );

`ifndef SEQ_STOP_ON_ERROR_EN
  assign abA = 1'b0;
  assign abB = 1'b0;
`endif

  always_comb begin
    rd     = (sel == 0) ? rdA   : rdB;
    wr     = (sel == 0) ? wrA   : wrB;
    busy   = (sel == 0) ? busyA : busyB;
    done   = (sel == 0) ? doneA : doneB;
    passed = (sel == 0) ? passA : passB;
    idx    = (sel == 0) ? idxA  : idxB;
    err    = (sel == 0) ? {30'd0, errA} : {16'd0, errB};
    ab     = (sel == 0) ? abA   : abB;
  end

  int assertCount = 0;
  int failCount   = 0;
  bit pat [64];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setPattern(input int mode);
    for (int k = 0; k < 64; k++) begin
      case (mode)
        0:       pat[k] = 1'b0;
        1:       pat[k] = 1'b1;
        2:       pat[k] = (k % 2) == 1;
        default: pat[k] = ($urandom_range(0, 2) == 0);
      endcase
    end
  endtask

  // One run: expected strobe times are read k at 1+k*DIV, its write LAT later, done one cycle after the last write.
  task automatic applyStimulus(input int s, input int size, input bit injectStart);
    int divS   = (s == 0) ? 10 : 2;
    int latS   = (s == 0) ? 3 : 4;
    int errMax = (s == 0) ? 3 : 65535;
    int nReads, expErr, expDone, budget, t;
    int rdSeen, wrSeen, rdBad, wrBad, idxBad;
    bit doneSeen, prevRd;
    nReads = size;
`ifdef SEQ_STOP_ON_ERROR_EN
    for (int k = 0; k < size; k++) begin
      if (pat[k]) begin
        nReads = (latS + k * divS) / divS + 1;
        if (nReads > size) nReads = size;
        break;
      end
    end
`endif
    expErr = 0;
    for (int k = 0; k < nReads; k++) if (pat[k]) expErr++;
    if (expErr > errMax) expErr = errMax;
    expDone = (nReads == 0) ? 1 : 1 + (nReads - 1) * divS + latS + 1;
    budget  = expDone + 20;

    sel = s;
    @(negedge clk);
    vs    = 16'(size);
    start = 1'b1;
    t = 0; rdSeen = 0; wrSeen = 0; rdBad = 0; wrBad = 0; idxBad = 0;
    doneSeen = 1'b0; prevRd = 1'b0;
    while (!doneSeen && t < budget) begin
      @(negedge clk);
      t++;
      if (t == 1) start = 1'b0;
      if (injectStart && t == 5) begin
        start = 1'b1;
        vs    = 16'd40;
      end else if (injectStart && t == 6) begin
        start = 1'b0;
      end
      if (prevRd && idx !== 16'(rdSeen - 1)) idxBad++;
      prevRd = rd;
      if (rd) begin
        if (rdSeen >= nReads || t != 1 + rdSeen * divS) rdBad++;
        rdSeen++;
      end
      if (wr) begin
        if (wrSeen >= nReads || t != 1 + wrSeen * divS + latS) wrBad++;
        mm = (wrSeen < 64) ? pat[wrSeen] : 1'b0;
        wrSeen++;
      end else begin
        mm = ($urandom_range(0, 3) == 0);
      end
      if (done) doneSeen = 1'b1;
    end
    mm = 1'b0;
    start = 1'b0;

    checkOutput("doneTime",   doneSeen ? 32'(t) : 32'hFFFF_FFFF, 32'(expDone));
    checkOutput("readCount",  32'(rdSeen), 32'(nReads));
    checkOutput("writeCount", 32'(wrSeen), 32'(nReads));
    checkOutput("readTiming", 32'(rdBad), 32'd0);
    checkOutput("writeTiming",32'(wrBad), 32'd0);
    checkOutput("pointIndex", 32'(idxBad), 32'd0);
    checkOutput("errorCount", err, 32'(expErr));
    checkOutput("testPassed", {31'd0, passed}, {31'd0, expErr == 0});
    checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
`ifdef SEQ_STOP_ON_ERROR_EN
    checkOutput("aborted",    {31'd0, ab}, {31'd0, expErr != 0});
`else
    checkOutput("aborted",    {31'd0, ab}, 32'd0);
`endif
  endtask

  initial begin
    int strobes;
    int busyCycles;
    rst = 1'b1; start = 1'b0; vs = '0; mm = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    checkOutput("resetReadA",  {31'd0, rdA},   32'd0);
    checkOutput("resetWriteA", {31'd0, wrA},   32'd0);
    checkOutput("resetBusyA",  {31'd0, busyA}, 32'd0);
    checkOutput("resetDoneA",  {31'd0, doneA}, 32'd0);
    checkOutput("resetPassA",  {31'd0, passA}, 32'd0);
    checkOutput("resetIdxB",   {16'd0, idxB},  32'd0);
    checkOutput("resetErrB",   {16'd0, errB},  32'd0);
    rst = 1'b0;

    $display("[TB] nominal run, 5 points, no mismatches");
    setPattern(0);
    applyStimulus(0, 5, 1'b0);

    $display("[TB] reset in the middle of a run");
    sel = 0;
    @(negedge clk);
    vs = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midResetBusy",  {31'd0, busyA},  32'd0);
    checkOutput("midResetIdx",   {16'd0, idxA},   32'd0);
    checkOutput("midResetDone",  {31'd0, doneA},  32'd0);
    rst = 1'b0;
    strobes = 0; busyCycles = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rdA || wrA) strobes++;
      if (busyA || doneA) busyCycles++;
    end
    checkOutput("postResetStrobes", 32'(strobes), 32'd0);
    checkOutput("postResetActive",  32'(busyCycles), 32'd0);

    $display("[TB] mismatches on points 1 and 3");
    setPattern(2);
    applyStimulus(0, 4, 1'b0);

    $display("[TB] empty vector");
    setPattern(1);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(1, 0, 1'b0);

    $display("[TB] saturation with 2-bit counter, start during run");
    setPattern(1);
    applyStimulus(0, 6, 1'b1);

    $display("[TB] coinciding strobes, DIV=2 LAT=4");
    setPattern(0);
    applyStimulus(1, 7, 1'b0);
    setPattern(3);
    applyStimulus(1, 9, 1'b0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      setPattern(3);
      applyStimulus(r % 2, $urandom_range(1, 9), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
